// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the architectural register file of the 16-bit CPU
// datapath: default geometry and the address/data types used by the file,
// its read ports and the surrounding datapath.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEFAULT_ADDR_BITS = 4;
    localparam int DEFAULT_WIDTH     = 16;

    typedef logic [DEFAULT_ADDR_BITS-1:0] reg_addr_t;
    typedef logic [DEFAULT_WIDTH-1:0]     reg_data_t;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One registered read port of the register file. Selects a register from the
// flattened storage bus, applies the zero-register override and (optionally)
// the write-through bypass, and captures the result when re is high. With re
// low the output holds its previous value.
//
// Optional build macro: REGFILE_BYPASS_EN adds the write-through compare and
// the we/waddr/wdata ports.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   re               read enable (capture on rising edge)
//   raddr            read address
//   we/waddr/wdata   write port snoop (only with REGFILE_BYPASS_EN)
//   regs             current contents of every storage register
//   rdata            registered read data
// -----------------------------------------------------------------------------
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ZERO_REG  = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  re,
    input  logic [ADDR_BITS-1:0]                  raddr,
`ifdef REGFILE_BYPASS_EN
    input  logic                                  we,
    input  logic [ADDR_BITS-1:0]                  waddr,
    input  logic [WIDTH-1:0]                      wdata,
`endif
    input  logic [(1<<ADDR_BITS)-1:0][WIDTH-1:0]  regs,
    output logic [WIDTH-1:0]                      rdata
);

    logic [WIDTH-1:0] sel;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        sel = regs[raddr];
`ifdef REGFILE_BYPASS_EN
        // Same-edge write to the address being read: forward the new data.
        if (we && (raddr == waddr)) begin
            sel = wdata;
        end
`endif
        // Zero-register override is applied last so it wins over the bypass.
        if ((ZERO_REG != 0) && (raddr == '0)) begin
            sel = '0;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= sel;
        end
    end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// Architectural register file: 2**ADDR_BITS registers of WIDTH bits, one
// synchronous write port and two registered read ports sharing one read
// enable. Reads return data one cycle after re; rvalid flags that cycle.
// Same-edge write/read of one address returns the old value unless the
// REGFILE_BYPASS_EN macro is defined, in which case the new data is forwarded.
// With ZERO_REG=1 register 0 reads as 0 and ignores writes.
//
// Optional build macro: REGFILE_BYPASS_EN (write-through bypass).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   we, waddr, wdata      write port
//   re                    read enable for both read ports
//   raddr_a, raddr_b      read addresses
//   rdata_a, rdata_b      registered read data
//   rvalid                high the cycle after an accepted read
// -----------------------------------------------------------------------------
module register_file
    import regfile_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ZERO_REG  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr_a,
    input  logic [ADDR_BITS-1:0] raddr_b,
    output logic [WIDTH-1:0]     rdata_a,
    output logic [WIDTH-1:0]     rdata_b,
    output logic                 rvalid
);

    localparam int NUM_REGS = 1 << ADDR_BITS;

    logic [NUM_REGS-1:0][WIDTH-1:0] storage;
    logic                           write_ok;

    // Writes to register 0 are dropped when it is the hard-wired zero.
    assign write_ok = we && !((ZERO_REG != 0) && (waddr == '0));

    // NOTE: the storage array is deliberately reset: the architecture
    // requires every register to read 0 after reset, so it is built from
    // resettable flops rather than an inferred RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            storage <= '0;
        end else if (write_ok) begin
            storage[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
        end
    end

    regfile_read_port #(
        .ADDR_BITS (ADDR_BITS),
        .WIDTH     (WIDTH),
        .ZERO_REG  (ZERO_REG)
    ) u_port_a (
        .clk   (clk),
        .rst_n (rst_n),
        .re    (re),
        .raddr (raddr_a),
`ifdef REGFILE_BYPASS_EN
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
`endif
        .regs  (storage),
        .rdata (rdata_a)
    );

    regfile_read_port #(
        .ADDR_BITS (ADDR_BITS),
        .WIDTH     (WIDTH),
        .ZERO_REG  (ZERO_REG)
    ) u_port_b (
        .clk   (clk),
        .rst_n (rst_n),
        .re    (re),
        .raddr (raddr_b),
`ifdef REGFILE_BYPASS_EN
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
`endif
        .regs  (storage),
        .rdata (rdata_b)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
// Drives two register files side by side (ZERO_REG=1 and ZERO_REG=0) from the
// same inputs. An array-based model tracks each one; a compare process checks
// both against it on every falling edge, and directed steps pin the model with
// hand-computed literals.
// -----------------------------------------------------------------------------
module tb_register_file;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      we;
    reg_addr_t waddr;
    reg_data_t wdata;
    logic      re;
    reg_addr_t raddr_a;
    reg_addr_t raddr_b;

    // Index 0: ZERO_REG=1 instance, index 1: ZERO_REG=0 instance.
    reg_data_t rdata_a [2];
    reg_data_t rdata_b [2];
    logic      rvalid  [2];

    int checks   = 0;
    int failures = 0;
    bit compare_on = 1'b0;

    always #5 clk = ~clk;

    register_file #(.ZERO_REG(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re      (re),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a[0]),
        .rdata_b (rdata_b[0]),
        .rvalid  (rvalid[0])
    );

    register_file #(.ZERO_REG(0)) dut_nz (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re      (re),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a[1]),
        .rdata_b (rdata_b[1]),
        .rvalid  (rvalid[1])
    );

    // ---------------- reference model ----------------
    reg_data_t mem   [2][16];
    reg_data_t exp_a [2];
    reg_data_t exp_b [2];
    logic      exp_v;

    // Architectural read value of register x as seen by a read on this edge.
    function automatic reg_data_t model_value(int k, reg_addr_t x);
        if (k == 0 && x == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && x == waddr) return wdata;
`endif
        return mem[k][x];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 16; r++) mem[k][r] <= '0;
                exp_a[k] <= '0;
                exp_b[k] <= '0;
            end
            exp_v <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (re) begin
                    exp_a[k] <= model_value(k, raddr_a);
                    exp_b[k] <= model_value(k, raddr_b);
                end
                if (we && !(k == 0 && waddr == 0)) mem[k][waddr] <= wdata;
            end
            exp_v <= re;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (compare_on) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("model rdata_a[%0d]", k), 32'(rdata_a[k]), 32'(exp_a[k]));
                check($sformatf("model rdata_b[%0d]", k), 32'(rdata_b[k]), 32'(exp_b[k]));
                check($sformatf("model rvalid[%0d]", k),  32'(rvalid[k]),  32'(exp_v));
            end
        end
    end

    // ---------------- stimulus ----------------
    // Advance past the next rising edge; inputs change 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic w, input int wa, input logic [15:0] wd,
                          input logic r, input int ra, input int rb);
        we      = w;
        waddr   = reg_addr_t'(wa);
        wdata   = wd;
        re      = r;
        raddr_a = reg_addr_t'(ra);
        raddr_b = reg_addr_t'(rb);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 16'h0, 0, 0, 0);
        cyc();
        compare_on = 1'b1;
        cyc();
        rst_n = 1'b1;

        // Reset clears storage and outputs asynchronously.
        set_in(1, 5, 16'hBEEF, 0, 0, 0); cyc();
        set_in(0, 0, 16'h0, 1, 5, 5);    cyc();
        check("pre-reset read r5", 32'(rdata_a[0]), 32'hBEEF);
        rst_n = 1'b0;
        set_in(0, 0, 16'h0, 0, 0, 0);
        #1;
        check("async reset rdata_a", 32'(rdata_a[0]), 32'h0);
        check("async reset rdata_b", 32'(rdata_b[0]), 32'h0);
        check("async reset rvalid",  32'(rvalid[0]),  32'h0);
        cyc(); cyc();
        rst_n = 1'b1;
        set_in(0, 0, 16'h0, 1, 5, 5); cyc();
        check("post-reset r5", 32'(rdata_a[0]), 32'h0);
        check("post-reset rvalid", 32'(rvalid[0]), 32'h1);

        // Write then read on both ports.
        set_in(1, 3, 16'h1234, 0, 0, 0); cyc();
        set_in(0, 0, 16'h0, 1, 3, 3);    cyc();
        check("r3 port a", 32'(rdata_a[0]), 32'h1234);
        check("r3 port b", 32'(rdata_b[0]), 32'h1234);
        check("r3 rvalid", 32'(rvalid[0]),  32'h1);

        // Zero register behaviour in both builds.
        set_in(1, 0, 16'hFFFF, 0, 0, 0); cyc();
        set_in(0, 0, 16'h0, 1, 0, 0);    cyc();
        check("r0 ZERO_REG=1", 32'(rdata_a[0]), 32'h0000);
        check("r0 ZERO_REG=0", 32'(rdata_a[1]), 32'hFFFF);

        // Same-edge write/read collision on r7; port b reads r3 independently.
        set_in(1, 7, 16'h0001, 0, 0, 0); cyc();
        set_in(1, 7, 16'h00AA, 1, 7, 3); cyc();
`ifdef REGFILE_BYPASS_EN
        check("collision r7", 32'(rdata_a[0]), 32'h00AA);
`else
        check("collision r7", 32'(rdata_a[0]), 32'h0001);
`endif
        check("collision port b r3", 32'(rdata_b[0]), 32'h1234);
        set_in(0, 0, 16'h0, 1, 7, 7); cyc();
        check("r7 after collision", 32'(rdata_a[0]), 32'h00AA);

        // Read hold while re is low.
        set_in(1, 2, 16'h5555, 0, 0, 0); cyc();
        set_in(0, 0, 16'h0, 1, 2, 2);    cyc();
        check("r2 first read", 32'(rdata_a[0]), 32'h5555);
        set_in(1, 2, 16'h6666, 0, 2, 2);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("hold rdata_a", 32'(rdata_a[0]), 32'h5555);
            check("hold rvalid",  32'(rvalid[0]),  32'h0);
        end
        set_in(0, 0, 16'h0, 1, 2, 2); cyc();
        check("r2 after hold", 32'(rdata_a[0]), 32'h6666);

        // Sweep: r_i = i*0x0101, then read pairs (i, 15-i).
        for (int i = 1; i < 16; i++) begin
            set_in(1, i, 16'(i * 16'h0101), 0, 0, 0);
            cyc();
        end
        for (int i = 0; i < 16; i++) begin
            set_in(0, 0, 16'h0, 1, i, 15 - i);
            cyc();
            check($sformatf("sweep a r%0d", i), 32'(rdata_a[0]), 32'(i * 16'h0101));
            check($sformatf("sweep b r%0d", 15 - i), 32'(rdata_b[0]), 32'((15 - i) * 16'h0101));
        end

        set_in(0, 0, 16'h0, 0, 0, 0);
        cyc();
        @(negedge clk);
        compare_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_register_file

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file for the 16-bit CPU datapath.
- Sits directly upstream of the operand-select multiplexers: its two registered read ports feed the ALU source muxes.
- Its single write port is driven by the write-back select mux.
- Synchronous write, registered read with read-enable hold, optional write-to-read bypass.

Parameters:
- ADDR_BITS, 4, log2 of register count (16 registers).
- WIDTH, 16, data width in bits.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes; when 0 register 0 is an ordinary register.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable.
- waddr  input  ADDR_BITS  write address.
- wdata  input  WIDTH  write data.
- re  input  1  read enable for both read ports.
- raddr_a  input  ADDR_BITS  read address, port A.
- raddr_b  input  ADDR_BITS  read address, port B.
- rdata_a  output  WIDTH  registered read data, port A.
- rdata_b  output  WIDTH  registered read data, port B.
- rvalid  output  1  high the cycle after an accepted read.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- While rst_n is low:
  - all 2**ADDR_BITS storage registers clear to 0;
  - rdata_a and rdata_b are 0;
  - rvalid is 0.
- Reset deassertion takes effect at the next rising edge. No special synchroniser is inside the block.
- Write:
  - On a rising edge with we=1, storage[waddr] <= wdata.
  - With ZERO_REG=1 and waddr=0, the write is discarded.
- Read, latency 1:
  - On a rising edge with re=1, rdata_a <= value(raddr_a), rdata_b <= value(raddr_b), and rvalid <= 1.
  - With re=0, rdata_a and rdata_b hold their previous values and rvalid <= 0.
- value(x) is storage[x], except:
  - with ZERO_REG=1 and x=0, value is 0;
  - with the bypass compiled in, the bypass rule below applies.
- Same-edge write and read to the same address, bypass not compiled:
  - read captures the OLD stored value;
  - the new value is visible from the next accepted read.
- Both ports reading the same address return identical data.
- Simultaneous re=1 and we=1 to different addresses is independent; no stall.
- Reset asserted mid-operation: outputs and storage clear immediately (asynchronously). Writes in flight are lost.
- No internal state machine beyond storage and output registers. rvalid is a one-deep status flag, not a handshake; no backpressure.
- Addresses are full-width, so every address is legal. No wrap or out-of-range case.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when we=1, re=1 and raddr_x == waddr on the same edge, rdata_x captures wdata (write-through).
  - The ZERO_REG rule takes priority: address 0 still reads 0 when ZERO_REG=1.
- Not defined: old-value semantics as above. No bypass comparators are synthesised.

Decomposition:
- Package regfile_pkg holds:
  - localparam DEFAULT_ADDR_BITS=4, DEFAULT_WIDTH=16;
  - typedef reg_addr_t (logic[ADDR_BITS-1:0]);
  - typedef reg_data_t (logic[WIDTH-1:0]).
- One sub-module: regfile_read_port.
  - Instantiated twice.
  - Contains the address-indexed select over the storage array, the zero-register override, the optional bypass compare and the output register with re hold.
  - Storage array and write logic stay in register_file.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles after writing r5=16'hBEEF -> rdata_a=rdata_b=0 and rvalid=0 immediately. Then read r5 -> 0.
- Write then read: write r3=16'h1234, next cycle re=1 with raddr_a=3 and raddr_b=3 -> one cycle later rdata_a=rdata_b=16'h1234 and rvalid=1.
- Zero register (ZERO_REG=1): write r0=16'hFFFF, then read r0 -> 16'h0000. With ZERO_REG=0 the same sequence returns 16'hFFFF.
- Same-edge collision with r7=16'h0001 stored: we=1, waddr=7, wdata=16'h00AA, re=1, raddr_a=7.
  - Expected rdata_a=16'h0001 without REGFILE_BYPASS_EN.
  - Expected 16'h00AA with it.
  - A following read of r7 returns 16'h00AA in both builds.
- Read hold: read r2=16'h5555, then drop re for 3 cycles while writing r2=16'h6666 -> rdata_a stays 16'h5555 and rvalid=0. Re-assert re -> 16'h6666.
- Exhaustive sweep: write r_i=i*16'h0101 for i=1..15, then read pairs (i, 15-i) -> each port matches the expected value one cycle after issue.
